// File: rtl/sm_color_detect.sv
// rtl/sm_color_detect.sv - TCS3200-style colour sensor sequencer and none/red/blue/green classifier
// Cycles R/G/B filters, counts sensor edges per gate window, then classifies with threshold and confirmation.
module sm_color_detect #(
    parameter int         GATE_CYCLES   = 400,
    parameter int         SETTLE_CYCLES = 40,
    parameter int         MIN_COUNT     = 8,
    parameter int         CONFIRM       = 2,
    parameter int         CNT_W         = 12,
    parameter logic [1:0] FREQ_SCALE    = 2'b10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sensor_out,
    output logic             s0,
    output logic             s1,
    output logic             s2,
    output logic             s3,
    output logic [1:0]       color,
    output logic             color_valid,
    output logic [CNT_W-1:0] red_count,
    output logic [CNT_W-1:0] green_count,
    output logic [CNT_W-1:0] blue_count
);

    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RUN_W   = $clog2(CONFIRM + 1);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(MIN_COUNT);
    localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(CONFIRM);

    localparam logic [1:0] FILT_R = 2'b00;
    localparam logic [1:0] FILT_G = 2'b11;
    localparam logic [1:0] FILT_B = 2'b01;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_RED   = 2'b01;
    localparam logic [1:0] CODE_BLUE  = 2'b10;
    localparam logic [1:0] CODE_GREEN = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SET_R,
        MEAS_R,
        SET_G,
        MEAS_G,
        SET_B,
        MEAS_B,
        CLASSIFY
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] work_q, work_d;
    logic [CNT_W-1:0] red_q, red_d;
    logic [CNT_W-1:0] green_q, green_d;
    logic [CNT_W-1:0] blue_q, blue_d;
    logic [1:0]       prev_cand_q, prev_cand_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [1:0]       color_q, color_d;
    logic             color_valid_q, color_valid_d;
    logic [1:0]       scale_q, scale_d;
    logic [1:0]       filt_q, filt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             dly_q, dly_d;

    logic             sens_rise;
    logic [CNT_W-1:0] work_inc;
    logic [CNT_W-1:0] win_cnt;
    logic [1:0]       win_code;
    logic [1:0]       cand;
    logic [RUN_W-1:0] run_next;

    always_comb begin
        sens_rise = sync2_q & ~dly_q;
        work_inc  = (sens_rise && (work_q != CNT_MAX)) ? work_q + 1'b1 : work_q;

        // Ties go to red, then green, then blue.
        if ((red_q >= green_q) && (red_q >= blue_q)) begin
            win_cnt  = red_q;
            win_code = CODE_RED;
        end else if (green_q >= blue_q) begin
            win_cnt  = green_q;
            win_code = CODE_GREEN;
        end else begin
            win_cnt  = blue_q;
            win_code = CODE_BLUE;
        end
        cand = (win_cnt < MIN_CNT) ? CODE_NONE : win_code;

        if (cand == prev_cand_q) begin
            run_next = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 1'b1;
        end else begin
            run_next = RUN_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        work_d        = work_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        prev_cand_d   = prev_cand_q;
        run_d         = run_q;
        color_d       = color_q;
        color_valid_d = 1'b0;
        sync1_d       = sensor_out;
        sync2_d       = sync1_q;
        dly_d         = sync2_q;
        scale_d       = enable ? FREQ_SCALE : 2'b00;

        if (!enable) begin
            state_d       = IDLE;
            tmr_d         = '0;
            work_d        = '0;
            prev_cand_d   = CODE_NONE;
            run_d         = '0;
            color_d       = CODE_NONE;
            color_valid_d = (color_q != CODE_NONE);
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SET_R;
                    tmr_d   = '0;
                    work_d  = '0;
                end
                SET_R, SET_G, SET_B: begin
                    work_d = '0;
                    if (tmr_q == SETTLE_LAST) begin
                        tmr_d = '0;
                        case (state_q)
                            SET_R:   state_d = MEAS_R;
                            SET_G:   state_d = MEAS_G;
                            default: state_d = MEAS_B;
                        endcase
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                MEAS_R, MEAS_G, MEAS_B: begin
                    work_d = work_inc;
                    if (tmr_q == GATE_LAST) begin
                        tmr_d = '0;
                        case (state_q)
                            MEAS_R: begin
                                red_d   = work_inc;
                                state_d = SET_G;
                            end
                            MEAS_G: begin
                                green_d = work_inc;
                                state_d = SET_B;
                            end
                            default: begin
                                blue_d  = work_inc;
                                state_d = CLASSIFY;
                            end
                        endcase
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                CLASSIFY: begin
                    prev_cand_d = cand;
                    run_d       = run_next;
                    if ((run_next == RUN_MAX) && (cand != color_q)) begin
                        color_d       = cand;
                        color_valid_d = 1'b1;
                    end
                    tmr_d   = '0;
                    state_d = SET_R;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Filter follows the next state so it is already correct on the first SET cycle.
        case (state_d)
            SET_G, MEAS_G: filt_d = FILT_G;
            SET_B, MEAS_B: filt_d = FILT_B;
            default:       filt_d = FILT_R;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tmr_q         <= '0;
            work_q        <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            prev_cand_q   <= CODE_NONE;
            run_q         <= '0;
            color_q       <= CODE_NONE;
            color_valid_q <= 1'b0;
            scale_q       <= 2'b00;
            filt_q        <= FILT_R;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            dly_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            work_q        <= work_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            prev_cand_q   <= prev_cand_d;
            run_q         <= run_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            scale_q       <= scale_d;
            filt_q        <= filt_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            dly_q         <= dly_d;
        end
    end

    assign s0          = scale_q[1];
    assign s1          = scale_q[0];
    assign s2          = filt_q[1];
    assign s3          = filt_q[0];
    assign color       = color_q;
    assign color_valid = color_valid_q;
    assign red_count   = red_q;
    assign green_count = green_q;
    assign blue_count  = blue_q;

endmodule

// File: tb/tb_sm_color_detect.sv
// tb/tb_sm_color_detect.sv - self-checking bench for sm_color_detect
// Sensor model follows the DUT filter select; per-frame expectations are queued and popped at frame end.
module tb_sm_color_detect;

    localparam int FRAME = 1321;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        sensor_out = 1'b0;
    logic        sensor_sat = 1'b0;

    logic        s0, s1, s2, s3;
    logic [1:0]  color;
    logic        color_valid;
    logic [11:0] red_count, green_count, blue_count;

    logic        t0, t1, t2, t3;
    logic [1:0]  t_color;
    logic        t_valid;
    logic [3:0]  t_red, t_green, t_blue;

    sm_color_detect dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_out(sensor_out),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3),
        .color(color), .color_valid(color_valid),
        .red_count(red_count), .green_count(green_count), .blue_count(blue_count)
    );

    sm_color_detect #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_out(sensor_sat),
        .s0(t0), .s1(t1), .s2(t2), .s3(t3),
        .color(t_color), .color_valid(t_valid),
        .red_count(t_red), .green_count(t_green), .blue_count(t_blue)
    );

    always #5 clk = ~clk;

    int per_r = 10, per_g = 40, per_b = 40;
    int ph = 0, ph_sat = 0;

    always @(negedge clk) begin
        int p;
        case ({s2, s3})
            2'b11:   p = per_g;
            2'b01:   p = per_b;
            default: p = per_r;
        endcase
        ph = (ph + 1 >= p) ? 0 : ph + 1;
        sensor_out = (ph < p / 2);
        ph_sat = (ph_sat + 1 >= 4) ? 0 : ph_sat + 1;
        sensor_sat = (ph_sat < 2);
    end

    int vcnt = 0;
    always @(posedge clk) if (color_valid) vcnt++;

    typedef struct {
        int         r;
        int         g;
        int         b;
        logic [1:0] color;
        logic       valid;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_total = 0;
    int         frame_no = 0;
    logic [1:0] m_prev = 2'b00;
    logic [1:0] m_color = 2'b00;
    int         m_run = 0;

    function automatic int mcount(input int p, input int w);
        int c;
        int mx;
        c  = 400 / p;
        mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_clear();
        m_prev  = 2'b00;
        m_color = 2'b00;
        m_run   = 0;
    endtask

    task automatic run_frame(input int pr, input int pg, input int pb, input int nwait);
        exp_t       e;
        logic [1:0] cand;
        int         mx;
        per_r = pr;
        per_g = pg;
        per_b = pb;
        e.r = mcount(pr, 12);
        e.g = mcount(pg, 12);
        e.b = mcount(pb, 12);
        if (e.r >= e.g && e.r >= e.b) begin
            mx = e.r; cand = 2'b01;
        end else if (e.g >= e.b) begin
            mx = e.g; cand = 2'b11;
        end else begin
            mx = e.b; cand = 2'b10;
        end
        if (mx < 8) cand = 2'b00;
        m_run  = (cand == m_prev) ? ((m_run >= 2) ? 2 : m_run + 1) : 1;
        m_prev = cand;
        e.valid = 1'b0;
        if (m_run == 2 && cand != m_color) begin
            m_color = cand;
            e.valid = 1'b1;
        end
        e.color = m_color;
        sb.push_back(e);

        repeat (nwait) @(posedge clk);
        @(negedge clk);
        frame_no++;
        e = sb.pop_front();
        checks += 6;
        if (int'(red_count) !== e.r) begin
            errors++; $display("FAIL red_count frame%0d: got %0d expected %0d", frame_no, red_count, e.r);
        end
        if (int'(green_count) !== e.g) begin
            errors++; $display("FAIL green_count frame%0d: got %0d expected %0d", frame_no, green_count, e.g);
        end
        if (int'(blue_count) !== e.b) begin
            errors++; $display("FAIL blue_count frame%0d: got %0d expected %0d", frame_no, blue_count, e.b);
        end
        if (color !== e.color) begin
            errors++; $display("FAIL color frame%0d: got %b expected %b", frame_no, color, e.color);
        end
        if (color_valid !== e.valid) begin
            errors++; $display("FAIL color_valid frame%0d: got %b expected %b", frame_no, color_valid, e.valid);
        end
        if (vcnt !== exp_total) begin
            errors++; $display("FAIL valid_pulses frame%0d: got %0d expected %0d", frame_no, vcnt, exp_total);
        end
        exp_total += int'(e.valid);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s0, s1, s2, s3, color, color_valid, red_count, green_count, blue_count} !== 43'd0) begin
            errors++;
            $display("FAIL reset_outputs: got s=%b%b%b%b color=%b v=%b r=%0d g=%0d b=%0d expected all 0",
                     s0, s1, s2, s3, color, color_valid, red_count, green_count, blue_count);
        end
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s0, s1, s2, s3, color} !== 6'd0) begin
            errors++; $display("FAIL idle_after_reset: got s=%b%b%b%b color=%b expected 0", s0, s1, s2, s3, color);
        end
    endtask

    task automatic test_red_dominant();
        enable = 1'b1;
        run_frame(10, 40, 40, FRAME + 1);
        checks++;
        if ({t_red, t_green, t_blue} !== 12'hfff) begin
            errors++; $display("FAIL saturation: got r=%0d g=%0d b=%0d expected 15 each", t_red, t_green, t_blue);
        end
        checks++;
        if ({s0, s1} !== 2'b10) begin
            errors++; $display("FAIL freq_scale: got %b expected 10", {s0, s1});
        end
        run_frame(10, 40, 40, FRAME);
    endtask

    task automatic test_green_blue();
        run_frame(40, 10, 40, FRAME);
        run_frame(40, 10, 40, FRAME);
        run_frame(40, 40, 10, FRAME);
        run_frame(40, 10, 40, FRAME);
        run_frame(40, 40, 10, FRAME);
        run_frame(40, 40, 10, FRAME);
    endtask

    task automatic test_below_threshold();
        run_frame(10, 40, 40, FRAME);
        run_frame(10, 40, 40, FRAME);
        run_frame(100, 100, 100, FRAME);
        run_frame(100, 100, 100, FRAME);
    endtask

    task automatic test_tie();
        run_frame(10, 10, 40, FRAME);
        run_frame(10, 10, 40, FRAME);
    endtask

    task automatic test_abort();
        logic exp_v;
        repeat (600) @(posedge clk);
        @(negedge clk);
        exp_v  = (color != 2'b00);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (color !== 2'b00) begin
            errors++; $display("FAIL abort_color: got %b expected 00", color);
        end
        if ({s0, s1, s2, s3} !== 4'b0000) begin
            errors++; $display("FAIL abort_select: got %b expected 0000", {s0, s1, s2, s3});
        end
        if (color_valid !== exp_v) begin
            errors++; $display("FAIL abort_valid: got %b expected %b", color_valid, exp_v);
        end
        if (red_count !== 12'd40 || blue_count !== 12'd10) begin
            errors++; $display("FAIL abort_retain: got r=%0d b=%0d expected r=40 b=10", red_count, blue_count);
        end
        exp_total += int'(exp_v);
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (color_valid !== 1'b0) begin
            errors++; $display("FAIL abort_valid_single: got %b expected 0", color_valid);
        end
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s0, s1, s2, s3} !== 4'b1000) begin
            errors++; $display("FAIL reenable_select: got %b expected 1000", {s0, s1, s2, s3});
        end
        run_frame(10, 40, 40, FRAME);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s0, s1, s2, s3, color, color_valid, red_count, green_count, blue_count} !== 43'd0) begin
            errors++;
            $display("FAIL midrun_reset: got s=%b%b%b%b color=%b v=%b r=%0d g=%0d b=%0d expected all 0",
                     s0, s1, s2, s3, color, color_valid, red_count, green_count, blue_count);
        end
        enable = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s0, s1, color, red_count} !== 16'd0) begin
            errors++; $display("FAIL post_reset_idle: got s01=%b color=%b r=%0d expected 0", {s0, s1}, color, red_count);
        end
    endtask

    initial begin
        test_reset();
        test_red_dominant();
        test_green_blue();
        test_below_threshold();
        test_tie();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
